d_skid_buffer: RTL and testbench

//  Full-throughput valid/ready register slice (skid buffer) built on async-reset flops.

---
 rtl/d_skid_buffer.sv | 120 ++++++++++++
 tb/tb_d_skid_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/d_skid_buffer.sv
// Full-throughput valid/ready register slice with a one-word skid entry.
// Every output (m_valid, m_data, s_ready, occupancy) comes straight from a flop.
module d_skid_buffer #(
    parameter int             WDT       = 1,
    parameter logic [WDT-1:0] RESET_VAL = {WDT{1'b0}}
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [WDT-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [WDT-1:0] m_data,
    output logic [1:0]     occupancy
);

    // The encoding doubles as the word count reported on occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           m_valid_q;
    logic           m_valid_d;
    logic           s_ready_q;
    logic           s_ready_d;
    logic [WDT-1:0] m_data_q;
    logic [WDT-1:0] m_data_d;
    logic [WDT-1:0] skid_q;
    logic [WDT-1:0] skid_d;
    logic [1:0]     occ_q;
    logic [1:0]     occ_d;
    logic           in_s;
    logic           out_s;

    assign in_s  = s_valid & s_ready_q;
    assign out_s = m_valid_q & m_ready;

    // Next-state and next-output logic; s_ready_q stays low in EMPTY only
    // until the first edge after reset release.
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        s_ready_d = s_ready_q;
        m_data_d  = m_data_q;
        skid_d    = skid_q;

        case (state_q)
            ST_EMPTY: begin
                s_ready_d = 1'b1;
                if (in_s) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    m_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (in_s && out_s) begin
                    m_data_d = s_data;
                end else if (in_s) begin
                    skid_d    = s_data;
                    s_ready_d = 1'b0;
                    state_d   = ST_FULL;
                end else if (out_s) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (out_s) begin
                    m_data_d  = skid_q;
                    s_ready_d = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d   = ST_EMPTY;
                m_valid_d = 1'b0;
                s_ready_d = 1'b0;
            end
        endcase

        occ_d = 2'(state_d);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            m_data_q  <= RESET_VAL;
            skid_q    <= RESET_VAL;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            m_data_q  <= m_data_d;
            skid_q    <= skid_d;
            occ_q     <= occ_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_d_skid_buffer.sv
// Self-checking bench for d_skid_buffer: directed vector table, hand-written
// reset/stall sequences and a randomized run against a queue model.
module tb_d_skid_buffer;

    localparam int         WDT    = 8;
    localparam logic [7:0] RV     = 8'h5A;
    localparam int         NWORDS = 10000;
    localparam int         CYCMAX = 80000;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    d_skid_buffer #(.WDT(WDT), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       ev;
        logic       er;
        logic [7:0] ed;
        logic [1:0] eo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic sv, logic [7:0] sd, logic mr,
                                logic ev, logic er, logic [7:0] ed, logic [1:0] eo);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr;
        v.ev = ev; v.er = er; v.ed = ed; v.eo = eo;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // queue model state for the randomized run
    logic [7:0] q[$];
    logic       exp_mv;
    logic       exp_sr;
    logic [7:0] exp_md;

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic pv;
        logic m_in;
        logic m_out;

        // ---- reset then idle
        do_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'(RV));

        // ---- directed vector table
        // first edge after release: word on s_data must not be taken
        add(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, RV,    2'd0);
        add(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 2'd1);
        for (int i = 1; i <= 16; i++)
            add(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 8'(i), 2'd1);
        // drain: m_data keeps the last word
        add(1'b0, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h10, 2'd0);
        // stall sequence A1, A2, A3
        add(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1);
        add(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'hA1, 2'd2);
        add(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1, 2'd2);
        add(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1, 2'd2);
        add(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1);
        add(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd0);
        // idle with garbage on s_data: nothing captured, m_ready ignored
        add(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA3, 2'd0);
        add(1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd0);

        foreach (tbl[i]) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            m_ready = tbl[i].mr;
            tick();
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].er));
            chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tbl[i].eo));
        end

        // ---- asynchronous reset while FULL
        s_valid = 1'b1; s_data = 8'hB1; m_ready = 1'b0;
        tick();
        s_data = 8'hB2;
        tick();
        s_valid = 1'b0;
        chk("full_occ", 32'(occupancy), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_m_data", 32'(m_data), 32'(RV));
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk("arst_edge_s_ready", 32'(s_ready), 32'd1);
        chk("arst_edge_m_valid", 32'(m_valid), 32'd0);
        chk("arst_edge_m_data", 32'(m_data), 32'(RV));

        // ---- randomized traffic against the queue model
        q.delete();
        exp_mv = 1'b0;
        exp_sr = 1'b1;
        exp_md = RV;
        sent = 0; rcvd = 0; cyc = 0;
        pv = 1'b0;
        while (rcvd < NWORDS && cyc < CYCMAX) begin
            if (!pv && sent < NWORDS)
                pv = 1'($urandom % 2);
            s_valid = pv;
            s_data  = pv ? 8'(sent) : 8'($urandom);
            m_ready = 1'($urandom % 2);
            m_in  = s_valid & exp_sr;
            m_out = exp_mv & m_ready;
            tick();
            cyc++;
            if (m_out) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (m_in) begin
                q.push_back(s_data);
                sent++;
                pv = 1'b0;
            end
            exp_mv = (q.size() > 0);
            exp_sr = (q.size() < 2);
            if (q.size() > 0)
                exp_md = q[0];
            chk("rnd_m_valid", 32'(m_valid), 32'(exp_mv));
            chk("rnd_s_ready", 32'(s_ready), 32'(exp_sr));
            chk("rnd_m_data", 32'(m_data), 32'(exp_md));
            chk("rnd_occ", 32'(occupancy), 32'(q.size()));
        end
        chk("rnd_words_done", 32'(rcvd), 32'(NWORDS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
